chan_input_trap: RTL
====================

CHAN_INPUT_TRAP -- requirements
Module: chan_input_trap

Interface
REQ-001 SHALL have parameter WIDTH, default 16, discrete input bits per channel (legal 1..16).
REQ-002 SHALL have parameter DBNC, default 4, debounce length in CLOCK cycles (0 = debounce bypassed).
REQ-003 SHALL have parameter EDGE, default 0, trap qualification: 0 = any change, 1 = 0->1 only, 2 = 1->0 only.
REQ-004 SHALL have port CLOCK  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port GOJAM  input  1  synchronous restart, active-high.
REQ-007 SHALL have port IN  input  WIDTH  raw asynchronous discretes, active-high.
REQ-008 SHALL have port RDSEL  input  1  channel read strobe, active-high.
REQ-009 SHALL have port WRSEL  input  1  mask write strobe, active-high.
REQ-010 SHALL have port CHWL_  input  WIDTH  write bus, active-low.
REQ-011 SHALL have port CHOR_  output  WIDTH  read bus, active-low, wire-OR compatible.
REQ-012 SHALL have port TRP  output  1  trap request pulse, active-high.
REQ-013 SHALL have port ARMED  output  1  trap armed status.

Function
REQ-014 SHALL pass each IN bit through a two-flop synchronizer (SYN) before any other use.
REQ-015 SHALL hold per-bit stable register STB and per-bit counter CNT of width clog2(DBNC+1).
REQ-016 SHALL, per bit, clear CNT when SYN equals STB; else increment CNT, and when CNT reaches DBNC-1, load STB from SYN and clear CNT in the same edge.
REQ-017 SHALL, with DBNC=0, load STB from SYN every cycle (no counters).
REQ-018 SHALL give IN-to-STB latency of exactly 2+DBNC cycles for a level held stable; any glitch shorter than DBNC cycles SHALL leave STB unchanged.
REQ-019 SHALL hold mask register MASK; WRSEL loads MASK with ~CHWL_ on the edge.
REQ-020 SHALL define a qualifying change as an STB bit updating this edge where MASK bit is 1 and direction matches EDGE.
REQ-021 SHALL register TRP=1 for exactly one cycle on the edge after a qualifying change occurs while ARMED=1; otherwise TRP=0.
REQ-022 SHALL clear ARMED on the edge TRP is set; further qualifying changes SHALL NOT pulse TRP until re-armed.
REQ-023 SHALL set ARMED on any edge with RDSEL=1 or WRSEL=1; re-arm SHALL take priority over clear in the same edge (TRP still pulses).
REQ-024 SHALL drive CHOR_ combinationally as ~STB when RDSEL=1, all ones otherwise.
REQ-025 SHALL NOT trap on MASK changes alone; a bit unmasked while already changed SHALL NOT trap retroactively.
REQ-026 SHALL have multiple bits changing in one edge produce a single TRP pulse.
REQ-027 SHALL, on WRSEL and qualifying change in the same edge, qualify with the old MASK.

Reset
REQ-028 SHALL, on rst (asynchronous), set SYN=0, STB=0, CNT=0, TRP=0, MASK=all ones, ARMED=1; CHOR_=all ones when RDSEL=0.
REQ-029 SHALL, on GOJAM=1 at an edge, apply the same values synchronously, overriding all other inputs that edge.
REQ-030 SHALL, with rst or GOJAM mid-debounce, discard the partial count; the input requires a full 2+DBNC cycles after release.

Verification
REQ-031 SHALL cover: WIDTH=16, DBNC=4, IN=16'h0001 held -> STB bit0=1 six cycles later, TRP one cycle after that, ARMED=0; RDSEL=1 -> CHOR_=16'hFFFE, ARMED=1 next edge.
REQ-032 SHALL cover: IN bit3 pulsed high 3 cycles (DBNC=4) -> STB unchanged, TRP never asserts.
REQ-033 SHALL cover: trap taken, then IN bit5 toggles without read -> no TRP; RDSEL then bit6 changes -> exactly one TRP.
REQ-034 SHALL cover: WRSEL with CHWL_=16'hFFFE (MASK=16'h0001), bit1 changes -> no TRP; bit0 changes -> TRP.
REQ-035 SHALL cover: EDGE=1, bit2 rises then falls -> one TRP on the rise only, after re-arm no TRP on the fall.
REQ-036 SHALL cover: rst asserted mid-debounce with IN=16'hFFFF -> outputs at reset values immediately; after release, STB=16'hFFFF after exactly 6 cycles.

Source files
------------

// File: rtl/chan_input_trap.sv
`default_nettype none
// ============================================================================
//  Module      : chan_input_trap
//  Description : Discrete input channel. Each input bit is synchronised and
//                debounced into a stable register. Masked changes of the
//                selected direction raise a single trap pulse, after which
//                the channel stays disarmed until it is read or written.
//  Revision    : 1.0 - initial release
// ============================================================================
module chan_input_trap #(
    parameter int WIDTH = 16,
    parameter int DBNC  = 4,
    parameter int EDGE  = 0
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic             GOJAM,
    input  logic [WIDTH-1:0] IN,
    input  logic             RDSEL,
    input  logic             WRSEL,
    input  logic [WIDTH-1:0] CHWL_,
    output logic [WIDTH-1:0] CHOR_,
    output logic             TRP,
    output logic             ARMED
);

    localparam int CNT_W = (DBNC > 0) ? $clog2(DBNC + 1) : 1;

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] syn_q,  syn_d;
    logic [WIDTH-1:0] stb_q,  stb_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             qual_q, qual_d;
    logic             trp_q,  trp_d;
    logic             armed_q, armed_d;

    logic [WIDTH-1:0] chg_rise;
    logic [WIDTH-1:0] chg_fall;
    logic [WIDTH-1:0] chg_dir;

    // Two-stage synchroniser for the raw asynchronous discretes
    always_comb begin
        meta_d = IN;
        syn_d  = meta_q;
        if (GOJAM) begin
            meta_d = '0;
            syn_d  = '0;
        end
    end

    generate
        if (DBNC > 0) begin : g_dbnc
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC - 1);
            localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

            logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

            // Per-bit debounce: a difference must persist DBNC cycles before STB follows
            always_comb begin
                stb_d = stb_q;
                cnt_d = cnt_q;
                for (int i = 0; i < WIDTH; i++) begin
                    if (syn_q[i] == stb_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        stb_d[i] = syn_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                if (GOJAM) begin
                    stb_d = '0;
                    cnt_d = '0;
                end
            end

            // Debounce counter storage
            always_ff @(posedge CLOCK or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_bypass
            // No debounce: stable register simply follows the synchroniser
            always_comb begin
                stb_d = GOJAM ? '0 : syn_q;
            end
        end
    endgenerate

    // Trap qualification, mask write and arm/disarm control
    always_comb begin
        chg_rise = stb_d & ~stb_q;
        chg_fall = ~stb_d & stb_q;
        if (EDGE == 1) begin
            chg_dir = chg_rise;
        end else if (EDGE == 2) begin
            chg_dir = chg_fall;
        end else begin
            chg_dir = chg_rise | chg_fall;
        end
        // Old mask qualifies the change even if WRSEL rewrites it this edge
        qual_d  = |(chg_dir & mask_q);
        mask_d  = WRSEL ? ~CHWL_ : mask_q;
        trp_d   = qual_q & armed_q;
        armed_d = armed_q;
        if (trp_d) begin
            armed_d = 1'b0;
        end
        // Re-arm wins over the disarm caused by a trap in the same edge
        if (RDSEL || WRSEL) begin
            armed_d = 1'b1;
        end
        if (GOJAM) begin
            qual_d  = 1'b0;
            mask_d  = '1;
            trp_d   = 1'b0;
            armed_d = 1'b1;
        end
    end

    // Main state registers
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            meta_q  <= '0;
            syn_q   <= '0;
            stb_q   <= '0;
            mask_q  <= '1;
            qual_q  <= 1'b0;
            trp_q   <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            meta_q  <= meta_d;
            syn_q   <= syn_d;
            stb_q   <= stb_d;
            mask_q  <= mask_d;
            qual_q  <= qual_d;
            trp_q   <= trp_d;
            armed_q <= armed_d;
        end
    end

    // Read bus is active-low and idles high so it can be wire-ORed
    always_comb begin
        CHOR_ = RDSEL ? ~stb_q : '1;
        TRP   = trp_q;
        ARMED = armed_q;
    end

endmodule
`default_nettype wire
